// File: rtl/crc_decode_one.sv
// Serial syndrome decoder for the (7,3) cyclic code with generator x^4+x^2+x+1.
// Three-step bit-serial division, then single-bit correction of the data field.
module crc_decode_one #(
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [6:0] i_code,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [2:0] o_data,
  output logic [3:0] o_syndrome,
  output logic       o_err,
  output logic       o_fixed,
  output logic       o_uncorr,
  output logic       o_done
);

  localparam int unsigned DIV_STEPS = 3;
  localparam int unsigned CNT_W     = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [3:0] GEN_LOW = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       r_q, r_next;
  logic [2:0]       data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       syn;
  logic             hit;
  logic [2:0]       data_flip;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = DIV;
      DIV:     if (cnt_q == CNT_LAST) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);

  // One long-division step: subtract the generator whenever the leading bit is set.
  always_comb begin
    if (r_q[6]) r_next = {r_q[5:2] ^ GEN_LOW, r_q[1:0], 1'b0};
    else        r_next = {r_q[5:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q    <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          r_q    <= i_code;
          data_q <= i_code[6:4];
          cnt_q  <= '0;
        end
        DIV: begin
          r_q   <= r_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign syn = r_q[6:3];

  // Map a single-error syndrome to its bit; only bits 6:4 touch the returned data.
  always_comb begin
    hit       = 1'b1;
    data_flip = 3'b000;
    case (syn)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: data_flip = 3'b000;
      4'b0111: data_flip = 3'b001;
      4'b1110: data_flip = 3'b010;
      4'b1011: data_flip = 3'b100;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data     <= '0;
      o_syndrome <= '0;
      o_err      <= 1'b0;
      o_fixed    <= 1'b0;
      o_uncorr   <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= (state_q == CHECK);
      if (state_q == CHECK) begin
        o_syndrome <= syn;
        o_err      <= (syn != 4'b0000);
        if (syn == 4'b0000) begin
          o_data   <= data_q;
          o_fixed  <= 1'b0;
          o_uncorr <= 1'b0;
        end else if (hit && CORRECT_EN) begin
          o_data   <= data_q ^ data_flip;
          o_fixed  <= 1'b1;
          o_uncorr <= 1'b0;
        end else begin
          o_data   <= data_q;
          o_fixed  <= 1'b0;
          o_uncorr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_decode_one.sv
// Bench for crc_decode_one: correcting and detect-only instances side by side,
// directed words plus random codewords with 0-2 bit errors against a polynomial model.
module tb_crc_decode_one;

  logic       clk, rst_n;
  logic [6:0] code;
  logic       valid;

  logic       ready0, err0, fixed0, uncorr0, done0;
  logic [2:0] data0;
  logic [3:0] syn0;
  logic       ready1, err1, fixed1, uncorr1, done1;
  logic [2:0] data1;
  logic [3:0] syn1;

  int n_checks = 0;
  int n_errors = 0;

  crc_decode_one u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_code(code), .i_valid(valid),
    .o_ready(ready0), .o_data(data0), .o_syndrome(syn0), .o_err(err0),
    .o_fixed(fixed0), .o_uncorr(uncorr0), .o_done(done0)
  );

  crc_decode_one #(.CORRECT_EN(1'b0)) u_dut_det (
    .i_clk(clk), .i_reset_n(rst_n), .i_code(code), .i_valid(valid),
    .o_ready(ready1), .o_data(data1), .o_syndrome(syn1), .o_err(err1),
    .o_fixed(fixed1), .o_uncorr(uncorr1), .o_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Remainder of the codeword polynomial modulo x^4+x^2+x+1.
  function automatic logic [3:0] m_syn(input logic [6:0] c);
    logic [6:0] rem;
    rem = c;
    for (int b = 6; b >= 4; b--)
      if (rem[b]) rem = rem ^ 7'(7'b0010111 << (b - 4));
    return rem[3:0];
  endfunction

  // Returns {data, fixed, uncorr}; correction by searching for the one flip that yields a codeword.
  function automatic logic [4:0] m_dec(input logic [6:0] c, input bit en);
    logic [6:0] t;
    if (m_syn(c) == 4'd0) return {c[6:4], 2'b00};
    if (en) begin
      for (int i = 0; i < 7; i++) begin
        t = c ^ 7'(7'd1 << i);
        if (m_syn(t) == 4'd0) return {t[6:4], 2'b10};
      end
    end
    return {c[6:4], 2'b01};
  endfunction

  task automatic check_results(input logic [6:0] c);
    logic [4:0] e1, e0;
    logic [3:0] s;
    s  = m_syn(c);
    e1 = m_dec(c, 1'b1);
    e0 = m_dec(c, 1'b0);
    check("syn",        16'(syn0),    16'(s));
    check("err",        16'(err0),    16'(s != 4'd0));
    check("data",       16'(data0),   16'(e1[4:2]));
    check("fixed",      16'(fixed0),  16'(e1[1]));
    check("uncorr",     16'(uncorr0), 16'(e1[0]));
    check("det_syn",    16'(syn1),    16'(s));
    check("det_err",    16'(err1),    16'(s != 4'd0));
    check("det_data",   16'(data1),   16'(e0[4:2]));
    check("det_fixed",  16'(fixed1),  16'(e0[1]));
    check("det_uncorr", 16'(uncorr1), 16'(e0[0]));
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (ready0) break;
      @(negedge clk);
    end
    check("ready_idle", 16'(ready0), 16'd1);
  endtask

  // Counts edges after acceptance until o_done appears (bounded).
  task automatic wait_done(output int lat);
    lat = 11;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) begin
        lat = k;
        break;
      end
      check("ready_busy", 16'(ready0), 16'd0);
    end
    check("done_det", 16'(done1), 16'd1);
    check("ready_back", 16'(ready0), 16'd1);
  endtask

  task automatic send_word(input logic [6:0] c);
    int lat;
    wait_ready();
    code  = c;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    code  = 7'(7'h7F & $urandom);
    check("ready_accept", 16'(ready0), 16'd0);
    wait_done(lat);
    check("done_lat", 16'(lat), 16'd4);
    check_results(c);
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", 16'(done0), 16'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [6:0] c;
    int nflip, idx;

    rst_n = 1'b0;
    valid = 1'b0;
    code  = '0;
    #25;
    check("rst_ready",  16'(ready0), 16'd1);
    check("rst_outs",   16'({data0, syn0, err0, fixed0, uncorr0, done0}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_word(7'h5C);
    send_word(7'h1C);
    send_word(7'h5E);
    send_word(7'h6C);

    // Back-to-back words with i_valid held high.
    wait_ready();
    code  = 7'h39;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    code = 7'h72;
    wait_done(lat);
    check("hold_lat1", 16'(lat), 16'd4);
    check_results(7'h39);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("hold_accept", 16'(ready0), 16'd0);
    wait_done(lat);
    check("hold_gap", 16'(lat + 1), 16'd5);
    check_results(7'h72);
    @(negedge clk);

    // Reset in the middle of a division.
    wait_ready();
    code  = 7'h1C;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 16'(ready0), 16'd1);
    check("midrst_outs",  16'({data0, syn0, err0, fixed0, uncorr0, done0}), 16'd0);
    check("midrst_det",   16'({data1, syn1, err1, fixed1, uncorr1, done1}), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (done0 || done1) seen = 1'b1;
    end
    check("midrst_nodone", 16'(seen), 16'd0);
    send_word(7'h72);

    // Random codewords with zero, one or two flipped bits and random idle gaps.
    for (int n = 0; n < 40; n++) begin
      c = {3'($urandom_range(0, 7)), 4'd0};
      c[3:0] = m_syn(c);
      nflip = int'($urandom_range(0, 2));
      for (int f = 0; f < nflip; f++) begin
        idx = int'($urandom_range(0, 6));
        c[idx] = ~c[idx];
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word(c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
